alu_host_driver: RTL and testbench
==================================

# alu_host_driver

Host-side initiator for the byte-serial floating-point ALU port. It accepts one 32-bit operand pair and an opcode on a valid/ready request channel. It serializes both operands LSB-first onto the ALU's 8-bit input bus behind a `start` pulse, then reassembles the four result bytes into a 32-bit response. It sits between a host or test controller and the ALU core, and hides the ALU's fixed-cycle byte protocol.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles in WAIT_DONE before an error response; legal range ≥ 3.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_a`  in  32  operand A (IEEE-754 single).
- `req_b`  in  32  operand B.
- `req_op`  in  2  opcode (00 add, 01 sub).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when high together with `rsp_valid`.
- `rsp_result`  out  32  reassembled result.
- `rsp_error`  out  1  timeout; `rsp_result` = 0 in this case.
- `alu_in`  out  8  byte to ALU `in`.
- `alu_opcode`  out  2  to ALU `opcode`.
- `alu_start`  out  1  to ALU `start`.
- `alu_out`  in  8  from ALU `out`.
- `alu_done`  in  1  from ALU `done`.

## Operation
- **Reset values.** All outputs are registered. On `rst`:
  - state = IDLE;
  - `req_ready` = 1;
  - `rsp_valid`, `rsp_error`, `alu_start` = 0;
  - `alu_in`, `alu_opcode` = 0;
  - `rsp_result` = 0;
  - `done_q` = 0.
- **IDLE.** `req_ready` = 1. On handshake, latch A, B, op → START. `req_ready` drops the next cycle and stays 0 until return to IDLE.
- **START.** One cycle: `alu_start` = 1 and `alu_opcode` = op. `alu_opcode` holds op until RESP is left.
- **SEND.** 8 cycles with a 3-bit byte counter. `alu_in` = A[7:0], A[15:8], A[23:16], A[31:24], B[7:0], B[15:8], B[23:16], B[31:24]. `alu_start` = 0. Counter wrap from 7 → WAIT_DONE.
- **WAIT_DONE.**
  - `alu_in` = 0. The timeout counter runs from 0.
  - Capture is on a rising edge of `alu_done` (`alu_done` && !`done_q`), where `done_q` is `alu_done` registered every cycle. On that edge, capture `alu_out` into result[7:0] → RECV.
  - If the counter reaches `TIMEOUT_CYCLES` with no edge → RESP with error.
- **RECV.** 3 cycles. Capture `alu_out` into result[15:8], [23:16], [31:24] on consecutive cycles → RESP. `alu_done` is not re-checked during RECV.
- **RESP.** `rsp_valid` = 1. `rsp_result` and `rsp_error` are held stable until the `rsp_ready` handshake, then → IDLE.
- **Edge and stale-level rules.**
  - A level-high `alu_done` already present on entry to WAIT_DONE is not an edge and is ignored.
  - `alu_done` transitions during IDLE, START or SEND are ignored.
- **`rst` mid-transaction.**
  - Abort immediately to reset values; no response is issued.
  - The host drives no ALU reset. The integrator must reset the ALU alongside, or the ALU FSM desynchronizes.
- **Request during a transaction.** A request arriving while busy is not accepted (`req_ready` = 0); `req_*` is sampled only at handshake.

## Timing
- **Transaction timeline.** Handshake in cycle C0. Then:
  - C1: `alu_start` = 1.
  - C2–C9: the eight operand bytes.
  - C10: WAIT_DONE entered.
  - C12: ALU `done` rises; capture byte 0.
  - C13–C15: bytes 1–3.
  - C16: `rsp_valid` = 1.
- **Latency.** Accept-to-response is 16 cycles when `rsp_ready` is held high.
- **Earliest next request.** Handshake at C17, giving `alu_start` at C18. The ALU is back in IDLE with `done` cleared by then.
- **Throughput.** One transaction per 17 cycles.
- **Timeout.** `rsp_valid` with `rsp_error` = 1 at C10 + `TIMEOUT_CYCLES` (C26 at default). The counter width is $clog2(`TIMEOUT_CYCLES`+1).

## Structure
- **Shared package** (`alu_pkg`):
  - state enum: IDLE, START, SEND, WAIT_DONE, RECV, RESP;
  - opcode constants OP_ADD = 2'b00, OP_SUB = 2'b01;
  - BYTES_PER_OPERAND = 4;
  - the ALU's state encoding (shared with the ALU and the bench).
- **Module split.** Single module; no sub-module. The byte counter and the timeout counter are local registers.

## Test plan
- **Add.** `req_a` = 0x3F800000, `req_b` = 0x40000000, op = 00 against the real ALU → `rsp_result` = 0x40400000, `rsp_error` = 0, `rsp_valid` exactly at C16. The bench checks `alu_in` C2–C9 = 00,00,80,3F,00,00,00,40.
- **Subtract, back-to-back.** 0x40400000 − 0x3F800000 with op = 01 → 0x40000000, with a second add request issued in C17 → both results correct. `alu_opcode` is stable through the ALU EXECUTE cycle.
- **Backpressure.** `rsp_ready` = 0 for 5 cycles after C16 → `rsp_valid` and `rsp_result` are held unchanged, `req_ready` = 0 throughout, and IDLE is reached the cycle after the handshake.
- **Timeout.** A stub ALU that never raises `done` → `rsp_valid` at C26 with `rsp_error` = 1 and `rsp_result` = 0.
- **Stale done.** A stub holds `done` high from C8 to C20 → no capture, timeout error at C26. A second run with a stub raising `done` late at C18 → capture from C18, `rsp_valid` at C22.
- **Reset mid-SEND.** `rst` asserted at C5 → all outputs at reset values the next cycle, no `rsp_valid`. After ALU and host are reset, a fresh add completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial floating-point ALU port: host driver
// states, opcodes, operand framing and the ALU core's own state encoding.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        WAIT_DONE,
        RECV,
        RESP
    } host_state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    localparam int BYTES_PER_OPERAND = 4;
    localparam int BYTES_PER_REQUEST = 2 * BYTES_PER_OPERAND;

    // The ALU core's own FSM encoding, kept here so host, core and bench agree.
    typedef enum logic [1:0] {
        ALU_IDLE,
        ALU_LOAD,
        ALU_EXECUTE,
        ALU_OUTPUT
    } alu_state_e;

    function automatic logic is_supported_op(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_host_driver.sv
// Host-side initiator for the byte-serial ALU: serializes an operand pair
// LSB-first behind a start pulse and reassembles the four result bytes.
module alu_host_driver
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_error,
    output logic [7:0]  alu_in,
    output logic [1:0]  alu_opcode,
    output logic        alu_start,
    input  logic [7:0]  alu_out,
    input  logic        alu_done
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] LAST_SEND_BYTE = 3'(BYTES_PER_REQUEST - 1);
    localparam logic [1:0] LAST_RECV_BYTE = 2'(BYTES_PER_OPERAND - 2);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    host_state_e        state_reg;
    logic [63:0]        operand_reg;
    logic [2:0]         byte_cnt_reg;
    logic [1:0]         recv_cnt_reg;
    logic [TW-1:0]      timeout_cnt_reg;
    logic [23:0]        result_reg;
    logic               done_q;
    logic               done_edge;

    // Only a fresh rising edge counts; a level left over from earlier is stale.
    assign done_edge = alu_done && !done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_error       <= 1'b0;
            rsp_result      <= '0;
            alu_start       <= 1'b0;
            alu_in          <= '0;
            alu_opcode      <= '0;
            operand_reg     <= '0;
            byte_cnt_reg    <= '0;
            recv_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
            result_reg      <= '0;
            done_q          <= 1'b0;
        end else begin
            done_q <= alu_done;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        operand_reg <= {req_b, req_a};
                        alu_opcode  <= req_op;
                        alu_start   <= 1'b1;
                        req_ready   <= 1'b0;
                        state_reg   <= START;
                    end
                end

                START: begin
                    alu_start    <= 1'b0;
                    alu_in       <= operand_reg[7:0];
                    operand_reg  <= operand_reg >> 8;
                    byte_cnt_reg <= '0;
                    state_reg    <= SEND;
                end

                SEND: begin
                    byte_cnt_reg <= byte_cnt_reg + 3'd1;
                    if (byte_cnt_reg == LAST_SEND_BYTE) begin
                        alu_in          <= '0;
                        timeout_cnt_reg <= '0;
                        state_reg       <= WAIT_DONE;
                    end else begin
                        alu_in      <= operand_reg[7:0];
                        operand_reg <= operand_reg >> 8;
                    end
                end

                WAIT_DONE: begin
                    if (done_edge) begin
                        result_reg   <= {alu_out, result_reg[23:8]};
                        recv_cnt_reg <= '0;
                        state_reg    <= RECV;
                    end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        rsp_valid  <= 1'b1;
                        rsp_error  <= 1'b1;
                        rsp_result <= '0;
                        state_reg  <= RESP;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end

                RECV: begin
                    // Bytes arrive on fixed consecutive cycles; done is not re-examined.
                    recv_cnt_reg <= recv_cnt_reg + 2'd1;
                    if (recv_cnt_reg == LAST_RECV_BYTE) begin
                        rsp_result <= {alu_out, result_reg};
                        rsp_error  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state_reg  <= RESP;
                    end else begin
                        result_reg <= {alu_out, result_reg[23:8]};
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rsp_error  <= 1'b0;
                        alu_opcode <= '0;
                        req_ready  <= 1'b1;
                        state_reg  <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_host_driver.sv
// Self-checking bench for alu_host_driver with a behavioural byte-serial ALU stub.
module tb_alu_host_driver;
    import alu_pkg::*;

    localparam int M_NORMAL = 0;
    localparam int M_LATE   = 1;
    localparam int M_NEVER  = 2;
    localparam int M_STALE  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [1:0]  req_op = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic [7:0]  alu_in;
    logic [1:0]  alu_opcode;
    logic        alu_start;
    logic [7:0]  alu_out = '0;
    logic        alu_done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int          stub_mode = M_NORMAL;
    int          st_cyc = -1;
    int          rel;
    int          rise;
    logic [63:0] stub_ab = '0;
    logic [31:0] stub_res;
    logic [1:0]  exp_op = '0;

    alu_host_driver #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .alu_in(alu_in), .alu_opcode(alu_opcode), .alu_start(alu_start),
        .alu_out(alu_out), .alu_done(alu_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ALU result: true float values for the known cases, a fixed mixing function otherwise.
    function automatic logic [31:0] stub_calc(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        if (op == OP_ADD && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == OP_ADD && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (op == OP_SUB && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
    endfunction

    // Stub ALU: start at S, bytes S+1..S+8, done + result bytes from S+rise for 4 cycles.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            st_cyc   = -1;
            alu_done = 1'b0;
            alu_out  = '0;
        end else begin
            if (alu_start) st_cyc = cyc;
            alu_done = 1'b0;
            alu_out  = 8'($urandom);
            if (st_cyc >= 0) begin
                rel = cyc - st_cyc;
                if (rel >= 1 && rel <= 8) stub_ab[8*(rel-1) +: 8] = alu_in;
                if (rel == 9) check_eq("alu_in_wait", 32'(alu_in), 32'h0);
                if (rel == 10) check_eq("opcode_exec", 32'(alu_opcode), 32'(exp_op));
                stub_res = stub_calc(stub_ab[31:0], stub_ab[63:32], exp_op);
                rise = (stub_mode == M_LATE) ? 17 : 11;
                if ((stub_mode == M_NORMAL || stub_mode == M_LATE) && rel >= rise && rel <= rise + 3) begin
                    alu_done = 1'b1;
                    alu_out  = stub_res[8*(rel-rise) +: 8];
                end
                if (stub_mode == M_STALE && rel >= 7 && rel <= 19) alu_done = 1'b1;
                if (rel > 40) st_cyc = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                             input int mode, output int c0);
        int t;
        t = 0;
        while (!req_ready && t < 60) begin
            tick();
            t++;
        end
        check_eq("req_ready_wait", 32'(req_ready), 32'h1);
        stub_mode = mode;
        exp_op    = op;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
        c0        = cyc;
        tick();
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 2'($urandom);
        check_eq("req_ready_drop", 32'(req_ready), 32'h0);
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input int mode, input int bp, input logic [31:0] exp_res,
                           input logic exp_err, input int exp_lat, output int c0);
        int t;
        logic [31:0] held;
        rsp_ready = (bp == 0);
        handshake(a, b, op, mode, c0);
        t = 0;
        while (!rsp_valid && t < 60) begin
            tick();
            t++;
        end
        check_eq("rsp_valid", 32'(rsp_valid), 32'h1);
        check_eq("latency", 32'(cyc - c0), 32'(exp_lat));
        check_eq("rsp_result", rsp_result, exp_res);
        check_eq("rsp_error", 32'(rsp_error), 32'(exp_err));
        held = rsp_result;
        for (int k = 0; k < bp; k++) begin
            tick();
            check_eq("bp_valid", 32'(rsp_valid), 32'h1);
            check_eq("bp_result", rsp_result, held);
            check_eq("bp_req_ready", 32'(req_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        tick();
        check_eq("rsp_drop", 32'(rsp_valid), 32'h0);
        check_eq("idle_ready", 32'(req_ready), 32'h1);
        check_eq("sent_a", stub_ab[31:0], a);
        check_eq("sent_b", stub_ab[63:32], b);
        $display("txn a=%h b=%h op=%0d mode=%0d bp=%0d -> result=%h err=%0d lat=%0d",
                 a, b, op, mode, bp, held, exp_err, exp_lat);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'h1);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check_eq({tag, "_rsp_error"}, 32'(rsp_error), 32'h0);
        check_eq({tag, "_rsp_result"}, rsp_result, 32'h0);
        check_eq({tag, "_alu_start"}, 32'(alu_start), 32'h0);
        check_eq({tag, "_alu_in"}, 32'(alu_in), 32'h0);
        check_eq({tag, "_alu_opcode"}, 32'(alu_opcode), 32'h0);
    endtask

    initial begin
        int c0, c1, mode, bp, lat;
        int saw_rsp;
        logic [31:0] a, b, res;
        logic [1:0] op;
        logic err;

        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Directed add and back-to-back subtract/add.
        run_txn(32'h3F800000, 32'h40000000, OP_ADD, M_NORMAL, 0, 32'h40400000, 1'b0, 16, c0);
        run_txn(32'h40400000, 32'h3F800000, OP_SUB, M_NORMAL, 0, 32'h40000000, 1'b0, 16, c0);
        run_txn(32'h3F800000, 32'h3F800000, OP_ADD, M_NORMAL, 0, 32'h40000000, 1'b0, 16, c1);
        check_eq("b2b_gap", 32'(c1 - c0), 32'd17);

        // Backpressure, timeout, stale done, late done.
        run_txn(32'h3F800000, 32'h40000000, OP_ADD, M_NORMAL, 5, 32'h40400000, 1'b0, 16, c0);
        run_txn(32'h12345678, 32'h9ABCDEF0, OP_ADD, M_NEVER, 0, 32'h0, 1'b1, 26, c0);
        run_txn(32'h11223344, 32'h55667788, OP_SUB, M_STALE, 0, 32'h0, 1'b1, 26, c0);
        run_txn(32'hCAFEBABE, 32'h0BADF00D, OP_SUB, M_LATE, 0,
                stub_calc(32'hCAFEBABE, 32'h0BADF00D, OP_SUB), 1'b0, 22, c0);

        // Reset asserted in the middle of SEND.
        handshake(32'h3F800000, 32'h40000000, OP_ADD, M_NORMAL, c0);
        while (cyc < c0 + 5) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        tick();
        rst = 1'b0;
        saw_rsp = 0;
        repeat (30) begin
            tick();
            if (rsp_valid) saw_rsp++;
        end
        check_eq("no_rsp_after_rst", 32'(saw_rsp), 32'h0);
        run_txn(32'h3F800000, 32'h40000000, OP_ADD, M_NORMAL, 0, 32'h40400000, 1'b0, 16, c0);

        // Randomized transactions.
        for (int i = 0; i < 14; i++) begin
            a    = $urandom;
            b    = $urandom;
            op   = 2'($urandom_range(0, 1));
            mode = $urandom_range(0, 3);
            bp   = $urandom_range(0, 3);
            if (mode == M_NEVER || mode == M_STALE) begin
                res = 32'h0;
                err = 1'b1;
                lat = 26;
            end else begin
                res = stub_calc(a, b, op);
                err = 1'b0;
                lat = (mode == M_LATE) ? 22 : 16;
            end
            run_txn(a, b, op, mode, bp, res, err, lat, c0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
